sm_twos_converter: RTL and testbench
====================================

Name: sm_twos_converter

Overview:
- Multi-lane, pipelined, bidirectional converter between sign-magnitude and two's-complement fixed-point words.
- Successor to the single-lane, single-register, one-direction neuron sign stage.
- Sits between the multiplier array and the accumulator/activation stages of a layer.
- Adds per-transaction direction select, valid/ready flow control with back-pressure, and per-lane edge-case flags (negative zero, saturation).

Parameters:
LANES, 4, number of independent lanes converted per transaction
MAG_W, 31, magnitude width; lane word width OUT_W = MAG_W+1 (localparam, not overridable)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
in_mode  in  1  0: sign-magnitude to two's complement (SM2TC); 1: two's complement to sign-magnitude (TC2SM)
in_sign  in  LANES  per-lane sign; used in SM2TC only
in_data  in  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]; SM2TC uses low MAG_W bits (MSB ignored); TC2SM uses all OUT_W bits
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts output
out_mode  out  1  in_mode carried with the transaction
out_data  out  LANES*OUT_W  SM2TC: two's-complement word; TC2SM: {sign, magnitude[MAG_W-1:0]}
out_flag  out  LANES  SM2TC: negative zero seen; TC2SM: saturation applied

Behaviour:
- Reset: rst_n low at a clock edge clears both stage-valid regs, out_data, out_flag and out_mode to 0. in_ready is high in the cycle after reset.
- Mid-operation reset discards all in-flight transactions with no output.
- Two-stage pipeline S1 -> S2; S2 drives the outputs.
- Latency: 2 cycles from accepted input to out_valid when unstalled. Throughput: 1 transaction/cycle.
- Handshake:
  - S2 can load when !s2_valid || out_ready.
  - S1 can load when !s1_valid || (S2 can load).
  - in_ready = S1 can load (combinational from out_ready; no other comb path in to out).
  - Transfer occurs on valid && ready.
  - out_data, out_flag and out_mode stay stable while out_valid && !out_ready.
  - A simultaneous pop of S2 and push into S1 in the same cycle must not lose or duplicate data.
- S1, SM2TC, per lane:
  - neg = in_sign & (mag != 0).
  - Register pre = neg ? {1'b1, ~mag} : {1'b0, mag}, plus inc = neg.
  - flag = in_sign & (mag == 0). Negative zero yields output 0, not -0 / all-ones.
- S1, TC2SM, per lane (x = in_data lane):
  - neg = x[MAG_W].
  - Register pre = neg ? ~x : x, plus inc = neg.
  - Register sat = (x == {1'b1, {MAG_W{1'b0}}}).
- S2, per lane:
  - sum = pre + inc, modulo 2^OUT_W.
  - SM2TC: out = sum; flag as registered.
  - TC2SM: if sat, out = {1'b1, {MAG_W{1'b1}}} (magnitude saturates to 2^MAG_W-1) and flag = 1. Otherwise out = {neg, sum[MAG_W-1:0]} and flag = 0. Zero input gives sign 0.
- SM2TC range: -(2^MAG_W-1) .. 2^MAG_W-1. It never overflows.
- Lanes are fully independent; mode is shared per transaction. Mode may change every transaction with no bubble.

Decomposition:
- Shared package sm_tc_pkg: MODE_SM2TC=1'b0 and MODE_TC2SM=1'b1 constants, plus lane slice helper functions.
- One natural sub-module: sm_tc_lane, holding the per-lane S1/S2 datapath and flag logic, instantiated LANES times via generate.
- Handshake/valid control lives in the top module.

Test Plan:
- LANES=2, MAG_W=7. SM2TC, lane0 sign=1 mag=5, lane1 sign=0 mag=127 -> 2 cycles later out lanes 0xFB, 0x7F; flags 0,0.
- SM2TC, sign=1 mag=0 -> out 0x00, flag 1. Sign=0 mag=0 -> 0x00, flag 0.
- TC2SM, lane0 0x80, lane1 0xFF -> lane0 0xFF flag 1 (saturated); lane1 0x81 flag 0. Also 0x00 -> 0x00.
- Back-pressure: stream 6 transactions with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 held. All 6 appear in order, unchanged and unduplicated; output held stable while stalled.
- Alternating in_mode every cycle with out_ready=1 -> one result per cycle, out_mode matches each transaction.
- rst_n low for 1 cycle with 2 transactions in flight -> out_valid 0 next cycle, both dropped, outputs 0; new input accepted immediately after.

Source files
------------

// File: rtl/sm_tc_pkg.sv
// Shared mode encoding and lane-slicing helper for the sign-magnitude /
// two's-complement converter.
package sm_tc_pkg;

  typedef enum logic {
    MODE_SM2TC = 1'b0,
    MODE_TC2SM = 1'b1
  } mode_e;

  // LSB position of a lane inside a flat lane-packed bus.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sm_twos_converter_if.sv
// Input/output stream bundle of the converter; master is the upstream/downstream
// side, slave is the converter itself.
interface sm_twos_converter_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned MAG_W = 31
);
  localparam int unsigned OUT_W = MAG_W + 1;

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_mode;
  logic [LANES-1:0]         in_sign;
  logic [LANES*OUT_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_mode;
  logic [LANES*OUT_W-1:0]   out_data;
  logic [LANES-1:0]         out_flag;

  modport master (
    output in_valid, in_mode, in_sign, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_flag
  );

  modport slave (
    input  in_valid, in_mode, in_sign, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_flag
  );
endinterface

// File: rtl/sm_tc_lane.sv
// One lane of the converter: S1 pre-inversion and edge-case detection,
// S2 increment and sign/saturation assembly.
module sm_tc_lane
  import sm_tc_pkg::*;
#(
  parameter  int unsigned MAG_W = 31,
  localparam int unsigned OUT_W = MAG_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_en,
  input  logic             s2_en,
  input  logic             mode1,
  input  logic             mode2,
  input  logic             sign,
  input  logic [OUT_W-1:0] word,
  output logic [OUT_W-1:0] result,
  output logic             flag
);

  localparam logic [OUT_W-1:0] MOST_NEG = {1'b1, {MAG_W{1'b0}}};

  logic [MAG_W-1:0] mag;
  logic             neg_d;
  logic [OUT_W-1:0] pre_d;
  logic             flag_d;

  logic [OUT_W-1:0] pre_q;
  logic             inc_q;
  logic             flag_q;

  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] result_d;

  // Flag register carries negative-zero in SM2TC and saturation in TC2SM.
  always_comb begin
    mag    = word[MAG_W-1:0];
    neg_d  = 1'b0;
    pre_d  = '0;
    flag_d = 1'b0;
    if (mode1 == MODE_SM2TC) begin
      neg_d  = sign && (mag != '0);
      pre_d  = neg_d ? {1'b1, ~mag} : {1'b0, mag};
      flag_d = sign && (mag == '0);
    end else begin
      neg_d  = word[MAG_W];
      pre_d  = neg_d ? ~word : word;
      flag_d = (word == MOST_NEG);
    end
  end

  always_comb begin
    sum = pre_q + {{MAG_W{1'b0}}, inc_q};
    if (mode2 == MODE_SM2TC) begin
      result_d = sum;
    end else if (flag_q) begin
      result_d = '1;
    end else begin
      result_d = {inc_q, sum[MAG_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q  <= '0;
      inc_q  <= 1'b0;
      flag_q <= 1'b0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      if (s1_en) begin
        pre_q  <= pre_d;
        inc_q  <= neg_d;
        flag_q <= flag_d;
      end
      if (s2_en) begin
        result <= result_d;
        flag   <= flag_q;
      end
    end
  end

endmodule

// File: rtl/sm_twos_converter.sv
// Multi-lane two-stage sign-magnitude <-> two's-complement converter with
// valid/ready flow control; lanes share the per-transaction mode.
module sm_twos_converter
  import sm_tc_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned MAG_W = 31
) (
  input logic               clk,
  input logic               rst_n,
  sm_twos_converter_if.slave bus
);

  localparam int unsigned OUT_W = MAG_W + 1;

  logic s1_valid;
  logic s2_valid;
  logic s1_mode;
  logic s1_can;
  logic s2_can;
  logic s1_en;
  logic s2_en;

  logic [OUT_W-1:0] lane_result [LANES];
  logic             lane_flag   [LANES];

  // S2 frees up on a pop, so S1 can accept in the same cycle it hands over.
  assign s2_can = !s2_valid || bus.out_ready;
  assign s1_can = !s1_valid || s2_can;
  assign s1_en  = bus.in_valid && s1_can;
  assign s2_en  = s1_valid && s2_can;

  assign bus.in_ready  = s1_can;
  assign bus.out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s1_mode      <= 1'b0;
      bus.out_mode <= 1'b0;
    end else begin
      if (s1_can) s1_valid <= bus.in_valid;
      if (s2_can) s2_valid <= s1_valid;
      if (s1_en)  s1_mode  <= bus.in_mode;
      if (s2_en)  bus.out_mode <= s1_mode;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sm_tc_lane #(
      .MAG_W(MAG_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .s1_en  (s1_en),
      .s2_en  (s2_en),
      .mode1  (bus.in_mode),
      .mode2  (s1_mode),
      .sign   (bus.in_sign[i]),
      .word   (bus.in_data[lane_lsb(i, OUT_W) +: OUT_W]),
      .result (lane_result[i]),
      .flag   (lane_flag[i])
    );
  end

  always_comb begin
    bus.out_data = '0;
    bus.out_flag = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      bus.out_data[i*OUT_W +: OUT_W] = lane_result[i];
      bus.out_flag[i]                = lane_flag[i];
    end
  end

endmodule

// File: tb/tb_sm_twos_converter.sv
// Directed bench for sm_twos_converter with LANES=2, MAG_W=7 (8-bit lane words).
module tb_sm_twos_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sm_twos_converter_if #(.LANES(2), .MAG_W(7)) bus ();

  sm_twos_converter #(.LANES(2), .MAG_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction into an empty pipeline and samples it two edges later.
  task automatic send_one(input logic mode, input logic [1:0] sign, input logic [15:0] data,
                          output logic [15:0] od, output logic [1:0] of,
                          output logic om, output logic ov);
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_sign   = sign;
    bus.in_data   = data;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    od = bus.out_data;
    of = bus.out_flag;
    om = bus.out_mode;
    ov = bus.out_valid;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_sign = '0; bus.in_data = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
    checks++; if (bus.out_flag !== 2'b00) begin errors++; $display("FAIL reset_out_flag got %b want 00", bus.out_flag); end
    checks++; if (bus.out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode got %b want 0", bus.out_mode); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_sm2tc();
    logic [15:0] od; logic [1:0] of; logic om, ov;
    // Latency: nothing visible after the first edge.
    bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_sign = 2'b01; bus.in_data = 16'h7F05;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sm_latency1 got %b want 0", bus.out_valid); end
    cycle();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sm_latency2 got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h7FFB) begin errors++; $display("FAIL sm_basic_data got %h want 7ffb", bus.out_data); end
    checks++; if (bus.out_flag !== 2'b00) begin errors++; $display("FAIL sm_basic_flag got %b want 00", bus.out_flag); end
    cycle();
    send_one(1'b0, 2'b01, 16'h0000, od, of, om, ov);
    checks++; if (od !== 16'h0000) begin errors++; $display("FAIL sm_negzero_data got %h want 0000", od); end
    checks++; if (of !== 2'b01) begin errors++; $display("FAIL sm_negzero_flag got %b want 01", of); end
    checks++; if (om !== 1'b0) begin errors++; $display("FAIL sm_negzero_mode got %b want 0", om); end
    cycle();
    // MSB of each lane word is ignored in SM2TC.
    send_one(1'b0, 2'b10, 16'h8180, od, of, om, ov);
    checks++; if (od !== 16'hFF00) begin errors++; $display("FAIL sm_msb_ignored_data got %h want ff00", od); end
    checks++; if (of !== 2'b00) begin errors++; $display("FAIL sm_msb_ignored_flag got %b want 00", of); end
    cycle();
  endtask

  task automatic test_tc2sm();
    logic [15:0] od; logic [1:0] of; logic om, ov;
    send_one(1'b1, 2'b11, 16'hFF80, od, of, om, ov);
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL tc_sat_valid got %b want 1", ov); end
    checks++; if (od !== 16'h81FF) begin errors++; $display("FAIL tc_sat_data got %h want 81ff", od); end
    checks++; if (of !== 2'b01) begin errors++; $display("FAIL tc_sat_flag got %b want 01", of); end
    checks++; if (om !== 1'b1) begin errors++; $display("FAIL tc_sat_mode got %b want 1", om); end
    cycle();
    send_one(1'b1, 2'b00, 16'h007F, od, of, om, ov);
    checks++; if (od !== 16'h007F) begin errors++; $display("FAIL tc_zero_pos_data got %h want 007f", od); end
    checks++; if (of !== 2'b00) begin errors++; $display("FAIL tc_zero_pos_flag got %b want 00", of); end
    cycle();
    send_one(1'b1, 2'b00, 16'hFE01, od, of, om, ov);
    checks++; if (od !== 16'h8201) begin errors++; $display("FAIL tc_small_data got %h want 8201", od); end
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [6];
    logic [15:0] held = '0;
    logic        held_ok = 1'b0;
    int sent = 0, recv = 0, stalls = 0;
    for (int k = 0; k < 6; k++) exp_q[k] = {8'h40 + 8'(k), 8'h20 + 8'(k)};
    bus.in_mode = 1'b0; bus.in_sign = 2'b00;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc < 6);
      bus.in_valid  = (sent < 6);
      bus.in_data   = (sent < 6) ? exp_q[sent] : 16'h0000;
      #2;
      if (held_ok) begin
        checks++; if (bus.out_data !== held || bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_hold got %h/%b want %h/1", bus.out_data, bus.out_valid, held);
        end
      end
      held_ok = 1'b0;
      if (!bus.in_ready) stalls++;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          checks++; if (bus.out_data !== exp_q[recv]) begin
            errors++; $display("FAIL stream_data[%0d] got %h want %h", recv, bus.out_data, exp_q[recv]);
          end
          recv++;
        end else begin
          held = bus.out_data; held_ok = 1'b1;
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cycle();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    checks++; if (recv !== 6) begin errors++; $display("FAIL stream_count got %0d want 6", recv); end
    checks++; if (stalls !== 3) begin errors++; $display("FAIL stream_in_ready_low got %0d want 3", stalls); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_no_dup got %b want 0", bus.out_valid); end
  endtask

  task automatic test_alternating();
    logic [15:0] exp_d;
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        bus.in_valid = 1'b1;
        bus.in_mode  = i[0];
        bus.in_sign  = 2'b11;
        bus.in_data  = i[0] ? 16'hFBFD : 16'h0503;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL alt_in_ready[%0d] got %b want 1", i, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
      cycle();
      if (i >= 1) begin
        exp_d = (((i - 1) % 2) == 1) ? 16'h8583 : 16'hFBFD;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL alt_valid[%0d] got %b want 1", i - 1, bus.out_valid); end
        checks++; if (bus.out_mode !== 1'((i - 1) % 2)) begin errors++; $display("FAIL alt_mode[%0d] got %b want %0d", i - 1, bus.out_mode, (i - 1) % 2); end
        checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL alt_data[%0d] got %h want %h", i - 1, bus.out_data, exp_d); end
      end
    end
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL alt_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_mode = 1'b1; bus.in_sign = 2'b00; bus.in_data = 16'h8080;
    cycle();
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFFFF) begin
      errors++; $display("FAIL midrst_pre got %b/%h want 1/ffff", bus.out_valid, bus.out_data);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0000 || bus.out_flag !== 2'b00 || bus.out_mode !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got %h/%b/%b want 0000/00/0", bus.out_data, bus.out_flag, bus.out_mode);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_sign = 2'b10; bus.in_data = 16'h017F;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_dropped got %b want 0", bus.out_valid); end
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFF7F) begin
      errors++; $display("FAIL midrst_new got %b/%h want 1/ff7f", bus.out_valid, bus.out_data);
    end
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_single got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_sm2tc();
    test_tc2sm();
    test_back_to_back();
    test_alternating();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
